// File: rtl/rob_ctrl.sv
// Circular reorder buffer: allocates at tail, marks done on writeback, retires from head in order.
// Commit handshake is valid/ready; alloc_ready depends only on registered occupancy and flush.
module rob_ctrl #(
  parameter int ROB_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic                      alloc_done,
  input  logic                      alloc_reg_write_en,
  input  logic [4:0]                alloc_reg_write_addr,
  input  logic [31:0]               alloc_pc,
  input  logic [7:0]                alloc_exc_type,
  output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
  input  logic                      wb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] wb_id,
  input  logic [31:0]               wb_data,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [ROB_ADDR_WIDTH-1:0] commit_id,
  output logic                      commit_reg_write_en,
  output logic [4:0]                commit_reg_write_addr,
  output logic [31:0]               commit_data,
  output logic [31:0]               commit_pc,
  output logic [7:0]                commit_exc_type,
  output logic [ROB_ADDR_WIDTH:0]   count,
  output logic                      empty,
  output logic                      full
);

  localparam int DEPTH = 2 ** ROB_ADDR_WIDTH;
  localparam logic [ROB_ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ROB_ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ROB_ADDR_WIDTH:0]   CNT_FULL = (ROB_ADDR_WIDTH+1)'(DEPTH);

  logic [ROB_ADDR_WIDTH-1:0] r_head;
  logic [ROB_ADDR_WIDTH-1:0] r_tail;
  logic [ROB_ADDR_WIDTH:0]   r_count;

  logic        r_valid [DEPTH];
  logic        r_done  [DEPTH];
  logic        r_rwe   [DEPTH];
  logic [4:0]  r_raddr [DEPTH];
  logic [31:0] r_pc    [DEPTH];
  logic [7:0]  r_exc   [DEPTH];
  logic [31:0] r_data  [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_alloc_fire;
  logic w_commit_fire;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_FULL);
  assign alloc_ready   = !w_full && !flush;
  assign commit_valid  = !w_empty && r_done[r_head] && !flush;
  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = commit_valid && commit_ready;

  assign alloc_id              = r_tail;
  assign commit_id             = r_head;
  assign commit_reg_write_en   = r_rwe[r_head];
  assign commit_reg_write_addr = r_raddr[r_head];
  assign commit_data           = r_data[r_head];
  assign commit_pc             = r_pc[r_head];
  assign commit_exc_type       = r_exc[r_head];
  assign count                 = r_count;
  assign empty                 = w_empty;
  assign full                  = w_full;

  // Later assignments win: a commit clears an entry even if it is written back in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
        r_rwe[i]   <= 1'b0;
        r_raddr[i] <= '0;
        r_pc[i]    <= '0;
        r_exc[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
      end
    end else begin
      if (wb_en && r_valid[wb_id]) begin
        r_done[wb_id] <= 1'b1;
        r_data[wb_id] <= wb_data;
      end
      if (w_commit_fire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + PTR_ONE;
      end
      if (w_alloc_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= alloc_done;
        r_rwe[r_tail]   <= alloc_reg_write_en;
        r_raddr[r_tail] <= alloc_reg_write_addr;
        r_pc[r_tail]    <= alloc_pc;
        r_exc[r_tail]   <= alloc_exc_type;
        r_data[r_tail]  <= '0;
        r_tail          <= r_tail + PTR_ONE;
      end
      case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Circular reorder-buffer controller that allocates ROB entries at dispatch, marks them complete on execution writeback, and retires them in program order at commit. It sits directly upstream of the per-entry line storage and the commit stage. It owns the head/tail pointers, occupancy count, and per-entry valid/done/result state. It presents the oldest completed entry to the commit stage through a valid/ready handshake.

## Interface
- ROB_ADDR_WIDTH, 4: entry index width; DEPTH = 2**ROB_ADDR_WIDTH (16).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discard all entries (exception/mispredict recovery).
- alloc_valid  in  1  dispatch requests an entry.
- alloc_ready  out  1  entry available; alloc fires when alloc_valid && alloc_ready.
- alloc_done  in  1  entry complete at dispatch (nop, exception-tagged).
- alloc_reg_write_en  in  1  instruction writes a GPR.
- alloc_reg_write_addr  in  5  destination GPR.
- alloc_pc  in  32  instruction PC.
- alloc_exc_type  in  8  exception code at dispatch; 0 = none.
- alloc_id  out  ROB_ADDR_WIDTH  index granted, equals tail pointer.
- wb_en  in  1  execution result valid.
- wb_id  in  ROB_ADDR_WIDTH  target entry.
- wb_data  in  32  result value.
- commit_valid  out  1  head entry present and done.
- commit_ready  in  1  commit stage accepts head.
- commit_id, commit_reg_write_en, commit_reg_write_addr, commit_data, commit_pc, commit_exc_type  out  ROB_ADDR_WIDTH/1/5/32/32/8  head entry fields.
- count  out  ROB_ADDR_WIDTH+1  occupied entries, 0..DEPTH.
- empty, full  out  1  count==0, count==DEPTH.

## Operation
- Per-entry state: valid, done, reg_write_en, reg_write_addr, pc, exc_type, data (data cleared to 0 on alloc).
- Alloc fire: entry[tail] <= {valid=1, done=alloc_done, fields}; tail <= tail+1 mod DEPTH.
- alloc_ready = !full && !flush; depends only on registered count, so a same-cycle commit does not free space for a same-cycle alloc.
- Writeback: if wb_en && valid[wb_id]: done <= 1, data <= wb_data. wb_en to invalid entry ignored. Repeated wb to done entry overwrites data.
- commit_valid = !empty && done[head] && !flush; commit_* fields driven combinationally from entry[head].
- Commit fire (commit_valid && commit_ready): valid[head], done[head] <= 0; head <= head+1 mod DEPTH.
- count: +1 on alloc fire only, -1 on commit fire only, unchanged when both or neither.
- Flush: highest priority below reset; head, tail, count <= 0; all valid/done <= 0; same-cycle alloc, wb, commit have no effect.
- Exceptions are not interpreted; exc_type passes through for the commit stage.

## Timing
- Reset (rst=0 at posedge): head=tail=count=0, all entry state 0. Outputs after reset: alloc_ready=1 (if flush=0), alloc_id=0, commit_valid=0, all commit_* fields 0, count=0, empty=1, full=0.
- Alloc with alloc_done=1: commit_valid rises the next cycle if the entry is at head.
- Writeback to head: commit_valid rises the next cycle, not the same cycle.
- Minimum dispatch-to-commit latency: 1 cycle. Throughput: 1 alloc + 1 wb + 1 commit per cycle.
- Pointers wrap DEPTH-1 -> 0. full and empty are distinguished by count, not by pointer compare.
- Reset or flush mid-stream: all in-flight entries are lost, with no commit of any of them. The next alloc gets id 0.

## Test plan
- Reset then 16 allocs (alloc_done=0, pc=0x100+4i) -> alloc_id 0..15, full=1, alloc_ready=0, count=16, commit_valid=0.
- wb_id=1 data 0xAA, then wb_id=0 data 0x55 -> commit_valid only after id 0 is done; commits in order: id0 data 0x55 pc 0x100, then id1 data 0xAA pc 0x104.
- Full ROB, head done, commit_ready=1 with alloc_valid=1 same cycle -> commit fires, alloc blocked, count 15; next cycle alloc fires with id 0 (wrap), count 16.
- wb_en to a freed index 5 -> no state change; a later alloc at index 5 reads data 0, done 0.
- 3 entries in flight with head done, flush=1 with commit_ready=1 and alloc_valid=1 -> commit_valid=0 that cycle; next cycle count=0, empty=1, alloc_id=0.
- alloc_done=1, alloc_exc_type=0x0C, reg_write_en=1 addr 7 into empty ROB -> next cycle commit_valid=1, commit_exc_type=0x0C, commit_reg_write_addr=7, commit_data=0.
